// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared widths, FSM state type and radix-4 Booth digit type for fp_mul_booth_seq
package fp_mul_pkg;
   localparam int FRAC_W = 23;
   localparam int MAN_W  = 24;
   localparam int PROD_W = 48;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [2:0] {BD_Z, BD_P1, BD_P2, BD_M1, BD_M2} booth_t;
   function automatic booth_t booth_dec(input logic [2:0] g);
      return (g == 3'b000 || g == 3'b111) ? BD_Z :
             (g == 3'b011) ? BD_P2 :
             (g == 3'b100) ? BD_M2 :
             g[2] ? BD_M1 : BD_P1;
   endfunction
endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: maps one overlapping 3-bit multiplier group to digit*multiplicand
//   grp_i   : {m[2i+1], m[2i], m[2i-1]}
//   mcand_i : unsigned multiplicand
//   pp_o    : signed partial product, digit in {-2,-1,0,+1,+2}
module booth_r4_recoder import fp_mul_pkg::*; #(
   parameter int W = 24
) (
   input  logic [2:0]          grp_i,
   input  logic [W-1:0]        mcand_i,
   output logic signed [W+1:0] pp_o
);
   booth_t dig;
   logic signed [W+1:0] m1, m2;
   assign dig  = booth_dec(grp_i);
   assign m1   = $signed({2'b00, mcand_i});
   assign m2   = $signed({1'b0, mcand_i, 1'b0});
   assign pp_o = dig == BD_P1 ? m1 :
                 dig == BD_P2 ? m2 :
                 dig == BD_M1 ? -m1 :
                 dig == BD_M2 ? -m2 : '0;
endmodule

// File: rtl/fp_mul_booth_seq.sv
// fp_mul_booth_seq: sequential radix-4 Booth mantissa multiplier, one digit per cycle
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   hid_X/frc_X, hid_Y/frc_Y : mantissas {hidden, fraction}
//   out_valid/out_ready  : product handshake, product held in DONE until taken
//   frc_Z_full           : unsigned 2*MAN_W-bit product, changes only on entry to DONE
//   busy                 : high outside IDLE
//   FP_MUL_EARLY_ZERO_EN : zero operand skips the Booth iterations (result after one edge)
module fp_mul_booth_seq import fp_mul_pkg::*; #(
   parameter int MAN_W = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MAN_W-2:0]     frc_X,
   input  logic [MAN_W-2:0]     frc_Y,
   input  logic                 hid_X,
   input  logic                 hid_Y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*MAN_W-1:0]   frc_Z_full,
   output logic                 busy
);
   localparam int PW    = 2*MAN_W;
   localparam int ACC_W = PW+2;
   localparam logic [3:0] LAST = 4'(MAN_W/2+1);
   state_t                    state_q;
   logic [MAN_W-1:0]          mcand_q;
   logic [MAN_W+2:0]          mplr_q;
   logic signed [ACC_W-1:0]   acc_q, acc_d, pp_ext;
   logic signed [MAN_W+1:0]   pp;
   logic [3:0]                cnt_q;
   logic [PW-1:0]             prod_q;
   logic                      out_valid_q;
`ifdef FP_MUL_EARLY_ZERO_EN
   logic                      zero_op;
   assign zero_op = ~|{hid_X, frc_X} | ~|{hid_Y, frc_Y};
`endif
   // mplr_q carries an extra LSB so [2:0] is always the current overlapping group
   booth_r4_recoder #(.W(MAN_W)) u_rec (
      .grp_i   (mplr_q[2:0]),
      .mcand_i (mcand_q),
      .pp_o    (pp)
   );
   assign pp_ext     = ACC_W'(pp);
   assign acc_d      = acc_q + (pp_ext <<< {cnt_q, 1'b0});
   assign in_ready   = state_q == IDLE;
   assign busy       = state_q != IDLE;
   assign out_valid  = out_valid_q;
   assign frc_Z_full = prod_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplr_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         prod_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               mcand_q <= {hid_X, frc_X};
               mplr_q  <= {2'b00, hid_Y, frc_Y, 1'b0};
               acc_q   <= '0;
               state_q <= CALC;
`ifdef FP_MUL_EARLY_ZERO_EN
               // jump straight to the result step; the cleared accumulator is the product
               cnt_q   <= zero_op ? LAST : 4'd0;
`else
               cnt_q   <= '0;
`endif
            end
            CALC: if (cnt_q == LAST) begin
               prod_q      <= acc_q[PW-1:0];
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end else begin
               acc_q  <= acc_d;
               mplr_q <= mplr_q >> 2;
               cnt_q  <= cnt_q + 4'd1;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// tb_fp_mul_booth_seq: directed scoreboard bench for fp_mul_booth_seq
module tb_fp_mul_booth_seq;
   localparam int MW = 24;
`ifdef FP_MUL_EARLY_ZERO_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 14;
`endif
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, hid_X = 1'b0, hid_Y = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, busy;
   logic [MW-2:0] frc_X = '0, frc_Y = '0;
   logic [2*MW-1:0] frc_Z_full, held;
   logic [2*MW-1:0] exp_q[$];
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   fp_mul_booth_seq #(.MAN_W(MW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .frc_X(frc_X), .frc_Y(frc_Y), .hid_X(hid_X), .hid_Y(hid_Y),
      .out_valid(out_valid), .out_ready(out_ready), .frc_Z_full(frc_Z_full), .busy(busy)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask
   function automatic logic [47:0] model(input logic hx, input logic [22:0] x, input logic hy, input logic [22:0] y);
      logic [47:0] a, b;
      a = 48'({hx, x});
      b = 48'({hy, y});
      return a * b;
   endfunction
   task automatic issue(input logic hx, input logic [22:0] x, input logic hy, input logic [22:0] y, input logic [47:0] e);
      @(negedge clk);
      in_valid = 1'b1; hid_X = hx; frc_X = x; hid_Y = hy; frc_Y = y;
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("busy_after_accept", 64'(busy), 64'd1);
   endtask
   task automatic collect(input string tag, input int lat);
      int n = 0;
      logic [47:0] e = 'x;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(lat));
      chk({tag, "_scoreboard_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_product"}, 64'(frc_Z_full), 64'(e));
   endtask
   task automatic handshake();
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("out_valid_fall", 64'(out_valid), 64'd0);
      chk("in_ready_after_hs", 64'(in_ready), 64'd1);
   endtask
   initial begin
      logic [22:0] rx, ry;
      logic rhx, rhy;
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frc_Z_full", 64'(frc_Z_full), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      issue(1'b1, 23'h2DF854, 1'b1, 23'h490FDB, 48'hADF854 * 48'hC90FDB);
      collect("pi_e", 14);
      handshake();
      chk("z_held_in_idle", 64'(frc_Z_full), 64'(48'hADF854 * 48'hC90FDB));
      issue(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 48'hFFFFFE000001);
      collect("max_max", 14);
      handshake();
      issue(1'b1, 23'h000000, 1'b1, 23'h490FDB, 48'h6487ED800000);
      collect("pow2_x", 14);
      handshake();
      issue(1'b0, 23'h000000, 1'b1, 23'h490FDB, 48'h0);
      collect("zero_x", ZLAT);
      handshake();
      issue(1'b1, 23'h7FFFFF, 1'b0, 23'h7FFFFF, model(1'b1, 23'h7FFFFF, 1'b0, 23'h7FFFFF));
      collect("subnorm_y", 14);
      handshake();
      issue(1'b1, 23'h555555, 1'b1, 23'h2AAAAA, model(1'b1, 23'h555555, 1'b1, 23'h2AAAAA));
      collect("alt_bits", 14);
      held = frc_Z_full;
      @(negedge clk);
      in_valid = 1'b1; hid_X = 1'b1; frc_X = 23'h0F0F0F; hid_Y = 1'b1; frc_Y = 23'h70F0F0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_z_stable", 64'(frc_Z_full), 64'(held));
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_out_valid", 64'(out_valid), 64'd1);
      end
      handshake();
      exp_q.push_back(model(1'b1, 23'h0F0F0F, 1'b1, 23'h70F0F0));
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("accept_after_hs", 64'(busy), 64'd1);
      collect("back_to_back", 14);
      handshake();
      issue(1'b1, 23'h123456, 1'b1, 23'h654321, model(1'b1, 23'h123456, 1'b1, 23'h654321));
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midcalc_rst_in_ready", 64'(in_ready), 64'd1);
      chk("midcalc_rst_out_valid", 64'(out_valid), 64'd0);
      chk("midcalc_rst_busy", 64'(busy), 64'd0);
      chk("midcalc_rst_frc_Z_full", 64'(frc_Z_full), 64'd0);
      void'(exp_q.pop_back());
      @(negedge clk) rst_n = 1'b1;
      repeat (16) begin
         @(posedge clk);
         #1 chk("abandoned_no_output", 64'(out_valid), 64'd0);
      end
      issue(1'b1, 23'h3C3C3C, 1'b1, 23'h0A0A0A, model(1'b1, 23'h3C3C3C, 1'b1, 23'h0A0A0A));
      collect("after_reset", 14);
      handshake();
      for (int k = 0; k < 6; k++) begin
         rx = 23'($urandom); ry = 23'($urandom);
         rhx = 1'($urandom); rhy = 1'($urandom);
         issue(rhx, rx, rhy, ry, model(rhx, rx, rhy, ry));
         collect("random", ({rhx, rx} == 24'd0 || {rhy, ry} == 24'd0) ? ZLAT : 14);
         handshake();
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
